// File: rtl/ring_pe_port.sv
// PE-side port of a two-phase ring: double-buffered injection and ejection
// slots that alternate between PE and router ownership on each ring phase.
module ring_pe_port #(
  parameter int DW = 64,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          polarity,
  input  logic          pesi,
  input  logic [DW-1:0] pedi,
  output logic          peri,
  output logic          inj_so,
  output logic [DW-1:0] inj_do,
  input  logic          inj_ri,
  input  logic          ej_si,
  input  logic [DW-1:0] ej_di,
  output logic          ej_ri,
  output logic          peso,
  output logic [DW-1:0] pedo,
  input  logic          pero,
  output logic [CW-1:0] tx_cnt,
  output logic [CW-1:0] rx_cnt,
  output logic          proto_err
);

  logic [1:0]    r_inj_full;
  logic [1:0]    r_ej_full;
  logic [DW-1:0] r_inj_data [2];
  logic [DW-1:0] r_ej_data  [2];
  logic [CW-1:0] r_tx_cnt;
  logic [CW-1:0] r_rx_cnt;
  logic          r_proto_err;

  logic w_pol;
  logic w_npol;
  logic w_inj_wr;
  logic w_inj_rd;
  logic w_ej_wr;
  logic w_ej_rd;
  logic w_viol;

  // The PE owns slot [polarity], the router owns slot [~polarity], so a
  // write and a drain in the same cycle can never target the same entry.
  assign w_pol  = polarity;
  assign w_npol = ~polarity;

  assign peri   = ~r_inj_full[w_pol];
  assign inj_so = r_inj_full[w_npol];
  assign inj_do = r_inj_data[w_npol];
  assign ej_ri  = ~r_ej_full[w_npol];
  assign peso   = r_ej_full[w_pol];
  assign pedo   = r_ej_data[w_pol];

  assign w_inj_wr = pesi & peri;
  assign w_inj_rd = inj_so & inj_ri;
  assign w_ej_wr  = ej_si & ej_ri;
  assign w_ej_rd  = peso & pero;
  assign w_viol   = (pesi & ~peri) | (ej_si & ~ej_ri);

  assign tx_cnt    = r_tx_cnt;
  assign rx_cnt    = r_rx_cnt;
  assign proto_err = r_proto_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inj_full    <= '0;
      r_inj_data[0] <= '0;
      r_inj_data[1] <= '0;
    end else begin
      if (w_inj_wr) begin
        r_inj_full[w_pol] <= 1'b1;
        r_inj_data[w_pol] <= pedi;
      end
      if (w_inj_rd) begin
        r_inj_full[w_npol] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ej_full    <= '0;
      r_ej_data[0] <= '0;
      r_ej_data[1] <= '0;
    end else begin
      if (w_ej_wr) begin
        r_ej_full[w_npol] <= 1'b1;
        r_ej_data[w_npol] <= ej_di;
      end
      if (w_ej_rd) begin
        r_ej_full[w_pol] <= 1'b0;
      end
    end
  end

  // Counters wrap naturally at 2^CW; the error flag is sticky until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_cnt    <= '0;
      r_rx_cnt    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_inj_rd) r_tx_cnt <= r_tx_cnt + 1'b1;
      if (w_ej_rd)  r_rx_cnt <= r_rx_cnt + 1'b1;
      if (w_viol)   r_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ring_pe_port.sv
// Directed bench for ring_pe_port, built with CW=4 so counter wrap is reachable.
module tb_ring_pe_port;
  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          polarity;
  logic          pesi;
  logic [DW-1:0] pedi;
  logic          peri;
  logic          inj_so;
  logic [DW-1:0] inj_do;
  logic          inj_ri;
  logic          ej_si;
  logic [DW-1:0] ej_di;
  logic          ej_ri;
  logic          peso;
  logic [DW-1:0] pedo;
  logic          pero;
  logic [CW-1:0] tx_cnt;
  logic [CW-1:0] rx_cnt;
  logic          proto_err;

  int errors = 0;
  int checks = 0;

  ring_pe_port #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .pesi(pesi), .pedi(pedi), .peri(peri),
    .inj_so(inj_so), .inj_do(inj_do), .inj_ri(inj_ri),
    .ej_si(ej_si), .ej_di(ej_di), .ej_ri(ej_ri),
    .peso(peso), .pedo(pedo), .pero(pero),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pesi = 1'b0; inj_ri = 1'b0; ej_si = 1'b0; pero = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; polarity = 1'b0; pedi = '0; ej_di = '0;
    idle();
    #2;
    checks++; if (peri !== 1'b1)      begin errors++; $display("FAIL rst_peri: got %b want 1", peri); end
    checks++; if (ej_ri !== 1'b1)     begin errors++; $display("FAIL rst_ej_ri: got %b want 1", ej_ri); end
    checks++; if (inj_so !== 1'b0)    begin errors++; $display("FAIL rst_inj_so: got %b want 0", inj_so); end
    checks++; if (peso !== 1'b0)      begin errors++; $display("FAIL rst_peso: got %b want 0", peso); end
    checks++; if (tx_cnt !== 4'd0)    begin errors++; $display("FAIL rst_tx_cnt: got %0d want 0", tx_cnt); end
    checks++; if (rx_cnt !== 4'd0)    begin errors++; $display("FAIL rst_rx_cnt: got %0d want 0", rx_cnt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err: got %b want 0", proto_err); end
    checks++; if (inj_do !== 64'd0)   begin errors++; $display("FAIL rst_inj_do: got %h want 0", inj_do); end
    #5 reset = 1'b1;
    tick();
  endtask

  task automatic test_inject();
    polarity = 1'b0; pesi = 1'b1; pedi = 64'h0001_0000_0000_0002;
    tick();
    pesi = 1'b0; pedi = '0; #1;
    checks++; if (peri !== 1'b0)   begin errors++; $display("FAIL inj_peri_busy: got %b want 0", peri); end
    checks++; if (inj_so !== 1'b0) begin errors++; $display("FAIL inj_so_same_phase: got %b want 0", inj_so); end
    polarity = 1'b1; inj_ri = 1'b1; #1;
    checks++; if (inj_so !== 1'b1) begin errors++; $display("FAIL inj_so_flip: got %b want 1", inj_so); end
    checks++; if (inj_do !== 64'h0001_0000_0000_0002) begin errors++; $display("FAIL inj_do: got %h want 0001000000000002", inj_do); end
    tick();
    inj_ri = 1'b0; #1;
    checks++; if (inj_so !== 1'b0) begin errors++; $display("FAIL inj_so_drained: got %b want 0", inj_so); end
    checks++; if (tx_cnt !== 4'd1) begin errors++; $display("FAIL inj_tx_cnt: got %0d want 1", tx_cnt); end
    polarity = 1'b0; #1;
    checks++; if (peri !== 1'b1)   begin errors++; $display("FAIL inj_peri_free: got %b want 1", peri); end
  endtask

  task automatic test_eject();
    polarity = 1'b1; ej_si = 1'b1; ej_di = 64'h4003_0000_0000_0003; pero = 1'b0; #1;
    checks++; if (ej_ri !== 1'b1) begin errors++; $display("FAIL ej_ri_empty: got %b want 1", ej_ri); end
    tick();
    ej_si = 1'b0; ej_di = '0; #1;
    checks++; if (ej_ri !== 1'b0) begin errors++; $display("FAIL ej_ri_full: got %b want 0", ej_ri); end
    checks++; if (peso !== 1'b0)  begin errors++; $display("FAIL ej_peso_same_phase: got %b want 0", peso); end
    polarity = 1'b0; #1;
    checks++; if (peso !== 1'b1)  begin errors++; $display("FAIL ej_peso_flip: got %b want 1", peso); end
    checks++; if (pedo !== 64'h4003_0000_0000_0003) begin errors++; $display("FAIL ej_pedo: got %h want 4003000000000003", pedo); end
    tick(); tick();
    checks++; if (peso !== 1'b1)  begin errors++; $display("FAIL ej_peso_held: got %b want 1", peso); end
    checks++; if (rx_cnt !== 4'd0) begin errors++; $display("FAIL ej_rx_cnt_held: got %0d want 0", rx_cnt); end
    pero = 1'b1;
    tick();
    pero = 1'b0; #1;
    checks++; if (rx_cnt !== 4'd1) begin errors++; $display("FAIL ej_rx_cnt: got %0d want 1", rx_cnt); end
    checks++; if (peso !== 1'b0)   begin errors++; $display("FAIL ej_peso_drained: got %b want 0", peso); end
  endtask

  task automatic test_back_to_back();
    polarity = 1'b1; pesi = 1'b1; pedi = 64'hAAAA_0000_1111_2222;
    tick();
    polarity = 1'b0; pesi = 1'b1; pedi = 64'hBBBB_5500_3333_4444; inj_ri = 1'b1; #1;
    checks++; if (inj_do !== 64'hAAAA_0000_1111_2222) begin errors++; $display("FAIL b2b_inj_do_a: got %h want aaaa000011112222", inj_do); end
    tick();
    pesi = 1'b0; inj_ri = 1'b0; #1;
    checks++; if (tx_cnt !== 4'd2) begin errors++; $display("FAIL b2b_tx_cnt: got %0d want 2", tx_cnt); end
    checks++; if (peri !== 1'b0)   begin errors++; $display("FAIL b2b_inj0_full: got %b want 0", peri); end
    polarity = 1'b1; #1;
    checks++; if (inj_so !== 1'b1) begin errors++; $display("FAIL b2b_inj_so_b: got %b want 1", inj_so); end
    checks++; if (inj_do !== 64'hBBBB_5500_3333_4444) begin errors++; $display("FAIL b2b_inj_do_b: got %h want bbbb550033334444", inj_do); end
    checks++; if (peri !== 1'b1)   begin errors++; $display("FAIL b2b_inj1_empty: got %b want 1", peri); end
    inj_ri = 1'b1;
    tick();
    inj_ri = 1'b0; #1;
    checks++; if (tx_cnt !== 4'd3) begin errors++; $display("FAIL b2b_tx_cnt2: got %0d want 3", tx_cnt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL b2b_no_err: got %b want 0", proto_err); end
  endtask

  task automatic test_overflow();
    polarity = 1'b0; pesi = 1'b1; pedi = 64'hC0C0_0000_0000_000C;
    tick();
    pedi = 64'hDDDD_0000_0000_000D;
    tick();
    pesi = 1'b0; #1;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL ovf_proto_err: got %b want 1", proto_err); end
    polarity = 1'b1; #1;
    checks++; if (inj_do !== 64'hC0C0_0000_0000_000C) begin errors++; $display("FAIL ovf_data_kept: got %h want c0c000000000000c", inj_do); end
    inj_ri = 1'b1;
    tick();
    inj_ri = 1'b0;
    tick(); tick();
    checks++; if (tx_cnt !== 4'd4)    begin errors++; $display("FAIL ovf_tx_cnt: got %0d want 4", tx_cnt); end
    checks++; if (inj_so !== 1'b0)    begin errors++; $display("FAIL ovf_one_packet: got %b want 0", inj_so); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", proto_err); end
  endtask

  task automatic test_async_reset();
    polarity = 1'b0; pesi = 1'b1; pedi = 64'h1000_0000_0000_0001; ej_si = 1'b1; ej_di = 64'h2000_0000_0000_0002;
    tick();
    polarity = 1'b1; pedi = 64'h3000_0000_0000_0003; ej_di = 64'h4000_0000_0000_0004;
    tick();
    idle(); #1;
    checks++; if ({peri, inj_so, ej_ri, peso} !== 4'b0101) begin errors++; $display("FAIL ar_all_full: got %b want 0101", {peri, inj_so, ej_ri, peso}); end
    reset = 1'b0; #1;
    checks++; if ({peri, inj_so, ej_ri, peso} !== 4'b1010) begin errors++; $display("FAIL ar_flags: got %b want 1010", {peri, inj_so, ej_ri, peso}); end
    checks++; if (tx_cnt !== 4'd0)    begin errors++; $display("FAIL ar_tx_cnt: got %0d want 0", tx_cnt); end
    checks++; if (rx_cnt !== 4'd0)    begin errors++; $display("FAIL ar_rx_cnt: got %0d want 0", rx_cnt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL ar_proto_err: got %b want 0", proto_err); end
    checks++; if (pedo !== 64'd0)     begin errors++; $display("FAIL ar_pedo: got %h want 0", pedo); end
    polarity = 1'b0; #1;
    checks++; if ({peri, inj_so, ej_ri, peso} !== 4'b1010) begin errors++; $display("FAIL ar_flags_p0: got %b want 1010", {peri, inj_so, ej_ri, peso}); end
    #1 reset = 1'b1;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) begin
      polarity = 1'b0; pesi = 1'b1; pedi = 64'h00FF_0000_0000_0000 | 64'(i);
      tick();
      pesi = 1'b0; polarity = 1'b1; inj_ri = 1'b1; #1;
      checks++; if (inj_do !== (64'h00FF_0000_0000_0000 | 64'(i))) begin errors++; $display("FAIL wrap_inj_do[%0d]: got %h want %h", i, inj_do, 64'h00FF_0000_0000_0000 | 64'(i)); end
      tick();
      inj_ri = 1'b0;
      if (i == 14) begin
        checks++; if (tx_cnt !== 4'hF) begin errors++; $display("FAIL wrap_all_ones: got %0d want 15", tx_cnt); end
      end
    end
    #1;
    checks++; if (tx_cnt !== 4'd0)    begin errors++; $display("FAIL wrap_zero: got %0d want 0", tx_cnt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL wrap_no_err: got %b want 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_inject();
    test_eject();
    test_back_to_back();
    test_overflow();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ring_pe_port.md
RING_PE_PORT -- requirements
Module: ring_pe_port

Interface
REQ-001 Parameter DW, default 64, packet width; field map [63] vc, [62] dir, [61:56] reserved, [55:48] hop, [47:32] source, [31:0] payload.
REQ-002 Parameter CW, default 16, statistics counter width.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 polarity  in  1  ring phase from ring controller; toggles per cycle or slower.
REQ-006 pesi  in  1  PE send valid.
REQ-007 pedi  in  DW  PE send data.
REQ-008 peri  out  1  PE send ready.
REQ-009 inj_so  out  1  injection packet valid toward router.
REQ-010 inj_do  out  DW  injection packet data.
REQ-011 inj_ri  in  1  router ready for injection.
REQ-012 ej_si  in  1  router ejection valid.
REQ-013 ej_di  in  DW  router ejection data.
REQ-014 ej_ri  out  1  ejection ready toward router.
REQ-015 peso  out  1  PE receive valid.
REQ-016 pedo  out  DW  PE receive data.
REQ-017 pero  in  1  PE receive ready.
REQ-018 tx_cnt  out  CW  packets handed to router.
REQ-019 rx_cnt  out  CW  packets handed to PE.
REQ-020 proto_err  out  1  sticky protocol violation flag.

Function
REQ-021 Block SHALL hold two one-entry injection buffers INJ[0..1] and two one-entry ejection buffers EJ[0..1], each with a full bit.
REQ-022 peri SHALL equal !INJ[polarity].full, combinationally.
REQ-023 pesi && peri SHALL write pedi unchanged into INJ[polarity] and set its full bit at the clock edge; pedi[63] does not select the buffer.
REQ-024 inj_so SHALL equal INJ[~polarity].full; inj_do SHALL equal INJ[~polarity].data.
REQ-025 inj_so && inj_ri SHALL clear INJ[~polarity].full and increment tx_cnt by 1.
REQ-026 ej_ri SHALL equal !EJ[~polarity].full; ej_si && ej_ri SHALL write ej_di into EJ[~polarity] and set full.
REQ-027 peso SHALL equal EJ[polarity].full; pedo SHALL equal EJ[polarity].data; peso && pero SHALL clear full and increment rx_cnt by 1.
REQ-028 Min latency PE write to inj_so: 1 cycle after write, gated by next polarity flip; router write to peso likewise.
REQ-029 Write and drain of the same buffer index in one cycle SHALL NOT occur (indices differ by polarity); writes and drains on different buffers in one cycle SHALL both take effect.
REQ-030 Counters SHALL wrap modulo 2^CW (all ones + 1 = 0).
REQ-031 pesi && !peri, or ej_si && !ej_ri, SHALL drop the data, leave all buffers unchanged, and set proto_err; proto_err clears only on reset.
REQ-032 pedo and inj_do SHALL hold last buffer contents when valid is low; consumers ignore data while valid low.
REQ-033 Buffer data SHALL be stored without modification of any field, including hop and reserved bits.

Reset
REQ-034 While reset=0: all full bits 0, buffer data 0, tx_cnt=0, rx_cnt=0, proto_err=0; hence peri=1, ej_ri=1, inj_so=0, peso=0.
REQ-035 Reset asserted mid-operation SHALL discard buffered packets immediately (asynchronous), without counter increments.
REQ-036 First edge after reset release SHALL accept handshakes normally.

Verification
REQ-037 polarity=0, pesi=1, pedi=0x0001_0000_0000_0002 one cycle -> peri=0 next cycle; after polarity=1 and inj_ri=1, inj_do=0x0001_0000_0000_0002, inj_so for one handshake, tx_cnt=1, peri=1 again when polarity returns to 0.
REQ-038 polarity=1, ej_si=1, ej_di=0x4003_0000_0000_0003, pero=0 -> ej_ri=0 while polarity=1; after polarity=0, peso=1 held across cycles until pero=1, then rx_cnt=1, peso=0.
REQ-039 Same-cycle PE write into INJ[0] and router drain of INJ[1] with polarity=0 -> both complete; tx_cnt increments by 1, INJ[0] full.
REQ-040 pesi=1 while INJ[polarity] full -> packet dropped, buffered data unchanged, proto_err=1 and stays 1 until reset.
REQ-041 Preload tx_cnt to all ones via 2^CW handshakes (CW=4 build: 16) -> tx_cnt=0 after 16th.
REQ-042 reset driven to 0 with all four buffers full, asynchronous to clk -> all full bits, counters, proto_err 0 before next edge; peri=1, ej_ri=1.
